// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaled sawtooth/triangle PWM counter with shadowed settings and boundary/peak strobes.
module pwm_timebase #(
  parameter int bitwidth = 10,
  parameter int prescaler_bitwidth = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [prescaler_bitwidth-1:0] prescaler,
  input  logic [bitwidth-1:0]           period,
  input  logic                          center_aligned,
  output logic [bitwidth-1:0]           counter,
  output logic                          load_enable,
  output logic                          peak,
  output logic                          counting_down
);
  logic [prescaler_bitwidth-1:0] pre_q = '0, pre_d, sh_pre_q = '0, sh_pre_d;
  logic [bitwidth-1:0] cnt_q = '0, cnt_d, sh_per_q = '0, sh_per_d, nxt;
  logic load_q = 1'b0, load_d, peak_q = 1'b0, peak_d, down_q = 1'b0, down_d;
  logic sh_ca_q = 1'b0, sh_ca_d;
  logic tick, top, rise, fall, bound;
  always_comb begin
    tick = enable && pre_q == sh_pre_q;
    top = cnt_q == sh_per_q;
    rise = sh_ca_q ? !down_q && !top : !top;
    // a zero period never descends: it sits at 0 and strobes every tick
    fall = sh_ca_q && !rise && sh_per_q != '0;
    nxt = rise ? cnt_q + 1'b1 : fall ? cnt_q - 1'b1 : '0;
    bound = !rise && nxt == '0;
    pre_d = tick ? '0 : enable ? pre_q + 1'b1 : pre_q;
    cnt_d = tick ? nxt : cnt_q;
    down_d = tick ? fall && nxt != '0 : down_q;
    load_d = tick && bound;
    peak_d = tick && nxt == sh_per_q;
    sh_per_d = load_d ? period : sh_per_q;
    sh_pre_d = load_d ? prescaler : sh_pre_q;
    sh_ca_d = load_d ? center_aligned : sh_ca_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
      load_q <= 1'b0;
      peak_q <= 1'b0;
      down_q <= 1'b0;
      sh_per_q <= period;
      sh_pre_q <= prescaler;
      sh_ca_q <= center_aligned;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      load_q <= load_d;
      peak_q <= peak_d;
      down_q <= down_d;
      sh_per_q <= sh_per_d;
      sh_pre_q <= sh_pre_d;
      sh_ca_q <= sh_ca_d;
    end
  end
  assign counter = cnt_q;
  assign load_enable = load_q;
  assign peak = peak_q;
  assign counting_down = down_q;
endmodule

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase: directed vector table plus a triangle-period sequence for pwm_timebase.
module tb_pwm_timebase;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, center_aligned = 1'b0;
  logic [7:0] prescaler = '0;
  logic [9:0] period = 10'd3, counter;
  logic load_enable, peak, counting_down;
  int errors = 0, checks = 0;
  typedef struct {
    logic rst, en;
    logic [7:0] pre;
    logic [9:0] per;
    logic ca;
    logic [9:0] cnt;
    logic ld, pk, dn, pkx;
  } vec_t;
  vec_t vq[$];

  pwm_timebase dut (
    .clock(clock), .reset(reset), .enable(enable), .prescaler(prescaler),
    .period(period), .center_aligned(center_aligned), .counter(counter),
    .load_enable(load_enable), .peak(peak), .counting_down(counting_down)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rst, en, input logic [7:0] pre, input logic [9:0] per,
                     input logic ca, input logic [9:0] cnt, input logic ld, pk, dn,
                     input logic pkx = 1'b0);
    vec_t v;
    v.rst = rst; v.en = en; v.pre = pre; v.per = per; v.ca = ca;
    v.cnt = cnt; v.ld = ld; v.pk = pk; v.dn = dn; v.pkx = pkx;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [9:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // sawtooth, P=3
    add(1,1,0,3,0, 0,0,0,0);
    add(0,1,0,3,0, 1,0,0,0); add(0,1,0,3,0, 2,0,0,0); add(0,1,0,3,0, 3,0,1,0);
    add(0,1,0,3,0, 0,1,0,0); add(0,1,0,3,0, 1,0,0,0); add(0,1,0,3,0, 2,0,0,0);
    add(0,1,0,3,0, 3,0,1,0); add(0,1,0,3,0, 0,1,0,0);
    // triangle, P=3
    add(1,1,0,3,1, 0,0,0,0);
    add(0,1,0,3,1, 1,0,0,0); add(0,1,0,3,1, 2,0,0,0); add(0,1,0,3,1, 3,0,1,0);
    add(0,1,0,3,1, 2,0,0,1); add(0,1,0,3,1, 1,0,0,1); add(0,1,0,3,1, 0,1,0,0);
    add(0,1,0,3,1, 1,0,0,0); add(0,1,0,3,1, 2,0,0,0); add(0,1,0,3,1, 3,0,1,0);
    add(0,1,0,3,1, 2,0,0,1);
    // period 5 -> 2 changed while counter=1
    add(1,1,0,5,0, 0,0,0,0); add(0,1,0,5,0, 1,0,0,0);
    add(0,1,0,2,0, 2,0,0,0); add(0,1,0,2,0, 3,0,0,0); add(0,1,0,2,0, 4,0,0,0);
    add(0,1,0,2,0, 5,0,1,0); add(0,1,0,2,0, 0,1,0,0); add(0,1,0,2,0, 1,0,0,0);
    add(0,1,0,2,0, 2,0,1,0); add(0,1,0,2,0, 0,1,0,0); add(0,1,0,2,0, 1,0,0,0);
    // prescaler=2, P=2, then enable low for 4 clocks
    add(1,1,2,2,0, 0,0,0,0);
    add(0,1,2,2,0, 0,0,0,0); add(0,1,2,2,0, 0,0,0,0); add(0,1,2,2,0, 1,0,0,0);
    add(0,1,2,2,0, 1,0,0,0); add(0,1,2,2,0, 1,0,0,0); add(0,1,2,2,0, 2,0,1,0);
    add(0,1,2,2,0, 2,0,0,0); add(0,1,2,2,0, 2,0,0,0); add(0,1,2,2,0, 0,1,0,0);
    add(0,1,2,2,0, 0,0,0,0); add(0,1,2,2,0, 0,0,0,0); add(0,1,2,2,0, 1,0,0,0);
    add(0,1,2,2,0, 1,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,2,2,0, 1,0,0,0);
    add(0,1,2,2,0, 1,0,0,0); add(0,1,2,2,0, 2,0,1,0);
    // reset while triangle descends at 4, new settings latched
    add(1,1,0,5,1, 0,0,0,0);
    add(0,1,0,5,1, 1,0,0,0); add(0,1,0,5,1, 2,0,0,0); add(0,1,0,5,1, 3,0,0,0);
    add(0,1,0,5,1, 4,0,0,0); add(0,1,0,5,1, 5,0,1,0); add(0,1,0,5,1, 4,0,0,1);
    add(1,1,0,3,0, 0,0,0,0);
    add(0,1,0,3,0, 1,0,0,0); add(0,1,0,3,0, 2,0,0,0); add(0,1,0,3,0, 3,0,1,0);
    add(0,1,0,3,0, 0,1,0,0); add(0,1,0,3,0, 1,0,0,0);
    // mode switch to triangle takes effect at the next boundary
    add(0,1,0,3,1, 2,0,0,0); add(0,1,0,3,1, 3,0,1,0); add(0,1,0,3,1, 0,1,0,0);
    add(0,1,0,3,1, 1,0,0,0); add(0,1,0,3,1, 2,0,0,0); add(0,1,0,3,1, 3,0,1,0);
    add(0,1,0,3,1, 2,0,0,1);
    // zero period in both modes
    add(1,1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0, 0,1,0,0,1);
    for (int i = 0; i < 3; i++) add(0,1,0,0,1, 0,1,0,0,1);

    chk("init_counter", -1, counter, 10'd0);
    chk("init_load", -1, {9'd0, load_enable}, 10'd0);
    foreach (vq[i]) begin
      @(negedge clock);
      reset = vq[i].rst; enable = vq[i].en; prescaler = vq[i].pre;
      period = vq[i].per; center_aligned = vq[i].ca;
      @(posedge clock);
      #1;
      chk("counter", i, counter, vq[i].cnt);
      chk("load_enable", i, {9'd0, load_enable}, {9'd0, vq[i].ld});
      if (!vq[i].pkx) chk("peak", i, {9'd0, peak}, {9'd0, vq[i].pk});
      chk("counting_down", i, {9'd0, counting_down}, {9'd0, vq[i].dn});
    end

    // triangle P=3 over 24 ticks: loads exactly every 6, peaks at 3 mod 6
    begin
      int loads, last, peaks;
      loads = 0; last = 0; peaks = 0;
      @(negedge clock);
      reset = 1; enable = 1; prescaler = 0; period = 3; center_aligned = 1;
      @(negedge clock);
      reset = 0;
      for (int t = 1; t <= 24; t++) begin
        @(posedge clock);
        #1;
        if (peak) begin
          peaks++;
          chk("tri_peak_phase", t, 10'(t % 6), 10'd3);
        end
        if (load_enable) begin
          loads++;
          chk("tri_load_interval", t, 10'(t - last), 10'd6);
          last = t;
        end
      end
      chk("tri_load_count", 0, 10'(loads), 10'd4);
      chk("tri_peak_count", 0, 10'(peaks), 10'd4);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
